// File: rtl/jk_ctrl_pkg.sv
// rtl/jk_ctrl_pkg.sv - shared state encodings and mod-7 counter constants
//
// Contents:
//   state_t    : sequencer states IDLE/GRANT/RUN/DONE
//   COUNT_W    : counter width
//   MOD7_LAST  : last code of the mod-7 cycle (110)
//   MOD7_RESET : code loaded by reset (111), left on the first enabled step

package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int               COUNT_W    = 3;
    localparam logic [COUNT_W-1:0] MOD7_LAST  = 3'b110;
    localparam logic [COUNT_W-1:0] MOD7_RESET = 3'b111;

endpackage

// File: rtl/jk_ff.sv
// rtl/jk_ff.sv - single JK flip-flop with asynchronous active-low reset
//
// Ports:
//   clk   : clock, rising edge
//   rstb  : asynchronous active-low reset, loads RESET_VALUE
//   j, k  : JK inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   q     : flip-flop output

module jk_ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rstb,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            q <= RESET_VALUE;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod7_counter.sv
// rtl/jk_mod7_counter.sv - mod-7 counter (000..110) built from three JK flip-flops
//
// Ports:
//   clk   : clock, rising edge
//   rstb  : asynchronous active-low reset, q -> 111
//   en    : step the counter one code this cycle
//   clr   : force q -> 000 on the next edge (wins over en)
//   q     : counter state

module jk_mod7_counter
    import jk_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic               clr,
    output logic [COUNT_W-1:0] q
);

    logic               at_end;
    logic [COUNT_W-1:0] j_step;
    logic [COUNT_W-1:0] k_step;
    logic [COUNT_W-1:0] j;
    logic [COUNT_W-1:0] k;

    // Codes 110 and 111 both go to 000 next; they share q[2:1] == 11.
    assign at_end = (q[2:1] == MOD7_LAST[2:1]);

    // Minimised JK excitation for 000->001->...->110->000, 111->000.
    //   bit0: set unless at the end code, always clear when high
    //   bit1: set on carry out of bit0, clear on carry or when bit2 is high
    //   bit2: set on carry out of bits 1:0, clear whenever bit1 is high
    assign j_step = {q[1] & q[0], q[0], ~at_end};
    assign k_step = {q[1], q[0] | q[2], 1'b1};

    always_comb begin
        j = '0;
        k = '0;
        if (clr) begin
            k = '1;
        end else if (en) begin
            j = j_step;
            k = k_step;
        end
    end

    for (genvar g = 0; g < COUNT_W; g++) begin : g_bit
        jk_ff #(
            .RESET_VALUE (MOD7_RESET[g])
        ) u_ff (
            .clk  (clk),
            .rstb (rstb),
            .j    (j[g]),
            .k    (k[g]),
            .q    (q[g])
        );
    end

endmodule

// File: rtl/jk_mod7_arbiter.sv
// rtl/jk_mod7_arbiter.sv - round-robin sequencer sharing one JK mod-7 counter
//
// Ports:
//   clk    : clock, rising edge
//   rstb   : asynchronous active-low reset
//   req    : level request per requester, held until done
//   steps  : per-requester step count, field i at [i*STEP_W +: STEP_W]
//   grant  : one-hot grant, high from GRANT through DONE
//   owner  : index of the current / last granted requester
//   busy   : high in GRANT, RUN and DONE
//   count  : counter state
//   done   : one-cycle pulse in DONE
//   abort  : one-cycle pulse with done when the owner dropped req during RUN
//   wrap   : (JK_MOD7_ARB_WRAP_IRQ_EN only) one-cycle pulse after a 110->000 step in RUN
//
// Build option: define JK_MOD7_ARB_WRAP_IRQ_EN to add the wrap output.

module jk_mod7_arbiter
    import jk_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int STEP_W  = 4
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*STEP_W-1:0] steps,
    output logic [NUM_REQ-1:0]        grant,
    output logic [1:0]                owner,
    output logic                      busy,
    output logic [COUNT_W-1:0]        count,
    output logic                      done,
    output logic                      abort
`ifdef JK_MOD7_ARB_WRAP_IRQ_EN
    ,
    output logic                      wrap
`endif
);

    state_t              state;
    logic [1:0]          rr_ptr;
    logic [STEP_W-1:0]   remaining;

    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [STEP_W-1:0]   pick_steps;
    logic                owner_req;
    logic                cnt_en;
    logic                cnt_clr;
    logic [1:0]          ptr_next;
    int                  best_off;
    int                  off;

    // Round-robin pick: the requester with the smallest distance from rr_ptr
    // (wrapping) wins.
    always_comb begin
        pick_valid = |req;
        pick_idx   = '0;
        best_off   = NUM_REQ;
        off        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            off = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
            if (req[i] && (off < best_off)) begin
                best_off = off;
                pick_idx = 2'(i);
            end
        end
    end

    always_comb begin
        pick_onehot = '0;
        pick_steps  = '0;
        owner_req   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == 2'(i)) begin
                pick_onehot[i] = 1'b1;
                pick_steps     = steps[i*STEP_W +: STEP_W];
            end
            if (owner == 2'(i)) begin
                owner_req = req[i];
            end
        end
    end

    assign ptr_next = (owner == 2'(NUM_REQ - 1)) ? 2'd0 : owner + 2'd1;

    // The counter is cleared during GRANT and stepped during RUN only while
    // the owner still holds its request; a dropped request freezes it.
    assign cnt_clr = (state == GRANT);
    assign cnt_en  = (state == RUN) && owner_req;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
            rr_ptr    <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= GRANT;
                        grant     <= pick_onehot;
                        owner     <= pick_idx;
                        remaining <= pick_steps;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    if (remaining == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!owner_req) begin
                        state <= DONE;
                        done  <= 1'b1;
                        abort <= 1'b1;
                    end else begin
                        remaining <= remaining - 1'b1;
                        // Leave on the edge where remaining reaches zero.
                        if (remaining == STEP_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    grant  <= '0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    abort  <= 1'b0;
                    rr_ptr <= ptr_next;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    jk_mod7_counter u_counter (
        .clk  (clk),
        .rstb (rstb),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .q    (count)
    );

`ifdef JK_MOD7_ARB_WRAP_IRQ_EN
    // Registered at the same edge the counter returns from 110 to 000.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wrap <= 1'b0;
        end else begin
            wrap <= cnt_en && (count == MOD7_LAST);
        end
    end
`endif

endmodule
